// File: rtl/avr_pkg.sv
// Shared definitions for the AVR data-memory responder:
// window defaults, read fill pattern, FIFO entry and decode region types.
package avr_pkg;

   localparam logic [15:0] RAM_BASE_DEF   = 16'h0100;
   localparam int          DEPTH_DEF      = 512;
   localparam logic [15:0] EXT_BASE_DEF   = 16'h0000;
   localparam int          FIFO_DEPTH_DEF = 4;

   // Returned for any read that does not hit RAM.
   localparam logic [7:0]  RD_FILL = 8'hFF;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } ext_entry_t;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_EXT,
      REG_UNMAP
   } region_e;

   // Even parity bit: stored alongside data so the 9-bit word XORs to 0.
   function automatic logic par8(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/avr_wr_fifo.sv
// Generic push/pop FIFO with count, full flag and a registered head.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, head_o, valid_o, full_o,
//        level_o (entry count), drop_o (push refused because full).
module avr_wr_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             valid_o,
   output logic             full_o,
   output logic [PW:0]      level_o,
   output logic             drop_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pop_ok;
   logic             push_ok;
   logic             full;
   logic             empty;

   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);

   // ack with nothing queued is ignored
   assign pop_ok  = pop_i & ~empty;
   // a full FIFO still takes a push when the head leaves that same edge
   assign push_ok = push_i & (~full | pop_ok);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop_ok)  rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      // head register tracks the entry that will sit at rptr_d
      if (pop_ok) begin
         if (cnt_q > (PW+1)'(1)) head_d = mem_q[rptr_d];
         else if (push_ok)       head_d = data_i;
      end else if (empty && push_ok) begin
         head_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   assign head_o  = head_q;
   assign valid_o = ~empty;
   assign full_o  = full;
   assign level_o = cnt_q;
   assign drop_o  = push_i & full & ~pop_ok;

endmodule

// File: rtl/avr_dmem.sv
// Data-memory responder: internal byte RAM, posted peripheral-write FIFO,
// sticky bus/parity error flags. Optional macro AVR_DMEM_PARITY_EN.
// Ports: CLK, RST_N, d_addr/data_write/d_wdata in, d_rdata out,
//        ext_req/ext_addr/ext_data/ext_ack handshake, fifo_full,
//        fifo_level, err, par_err, err_clr.
module avr_dmem
   import avr_pkg::*;
#(
   parameter logic [15:0] RAM_BASE   = RAM_BASE_DEF,
   parameter int          DEPTH      = DEPTH_DEF,
   parameter logic [15:0] EXT_BASE   = EXT_BASE_DEF,
   parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [15:0]                 d_addr,
   input  logic                        data_write,
   input  logic [7:0]                  d_wdata,
   output logic [7:0]                  d_rdata,
   output logic                        ext_req,
   output logic [7:0]                  ext_addr,
   output logic [7:0]                  ext_data,
   input  logic                        ext_ack,
   output logic                        fifo_full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        err,
   output logic                        par_err,
   input  logic                        err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef AVR_DMEM_PARITY_EN
   localparam int MW = 9;
`else
   localparam int MW = 8;
`endif

   logic [MW-1:0] mem_q [DEPTH];
   logic [16:0]   a17;
   logic          ram_hit;
   logic          ext_hit;
   region_e       region;
   logic [AW-1:0] ram_idx;
   logic [7:0]    ext_off;
   logic          ram_we;
   logic          ext_push;
   logic          unmap_wr;
   logic [MW-1:0] rd_word;
   logic [MW-1:0] wr_word;
   logic [7:0]    rdata_q, rdata_d;
   logic          err_q, err_d;
   ext_entry_t    push_ent;
   ext_entry_t    head_ent;
   logic          fifo_drop;
   logic          fifo_vld;
   logic [LW-1:0] level_w;

   // 17-bit compares so a window ending at 16'hFFFF cannot wrap
   assign a17     = {1'b0, d_addr};
   assign ram_hit = (a17 >= {1'b0, RAM_BASE}) &&
                    (a17 <  ({1'b0, RAM_BASE} + 17'(DEPTH)));
   assign ext_hit = (a17 >= {1'b0, EXT_BASE}) &&
                    (a17 <  ({1'b0, EXT_BASE} + 17'd256));

   always_comb begin
      region = REG_UNMAP;
      if (ram_hit)      region = REG_RAM;
      else if (ext_hit) region = REG_EXT;
   end

   assign ram_idx  = AW'(d_addr - RAM_BASE);
   assign ext_off  = 8'(d_addr - EXT_BASE);
   assign ram_we   = data_write & (region == REG_RAM);
   assign ext_push = data_write & (region == REG_EXT);
   assign unmap_wr = data_write & (region == REG_UNMAP);
   assign rd_word  = mem_q[ram_idx];

`ifdef AVR_DMEM_PARITY_EN
   assign wr_word = {par8(d_wdata), d_wdata};
`else
   assign wr_word = d_wdata;
`endif

   always_ff @(posedge CLK) begin
      if (ram_we) mem_q[ram_idx] <= wr_word;
   end

   always_comb begin
      rdata_d = RD_FILL;
      unique case (region)
         REG_RAM: rdata_d = ram_we ? d_wdata : rd_word[7:0];
         default: rdata_d = RD_FILL;
      endcase
   end

   assign push_ent = '{addr: ext_off, data: d_wdata};

   avr_wr_fifo #(
      .WIDTH ($bits(ext_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .push_i  (ext_push),
      .data_i  (push_ent),
      .pop_i   (ext_ack),
      .head_o  (head_ent),
      .valid_o (fifo_vld),
      .full_o  (fifo_full),
      .level_o (level_w),
      .drop_o  (fifo_drop)
   );

   // set wins over clear
   always_comb begin
      err_d = err_q;
      if (unmap_wr | fifo_drop) err_d = 1'b1;
      else if (err_clr)         err_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

`ifdef AVR_DMEM_PARITY_EN
   logic par_bad_q, par_bad_d;
   logic par_err_q, par_err_d;

   // captured with d_rdata; forwarded write data is never checked
   assign par_bad_d = (region == REG_RAM) & ~ram_we & (^rd_word);

   always_comb begin
      par_err_d = par_err_q;
      if (par_bad_q)    par_err_d = 1'b1;
      else if (err_clr) par_err_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         par_bad_q <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
         par_err_q <= par_err_d;
      end
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   assign d_rdata    = rdata_q;
   assign ext_req    = fifo_vld;
   assign ext_addr   = head_ent.addr;
   assign ext_data   = head_ent.data;
   assign fifo_level = level_w;
   assign err        = err_q;

endmodule

// File: tb/tb_avr_dmem.sv
// Directed bench for avr_dmem with a read-data scoreboard
// and a reference model of RAM, posted-write FIFO and error flags.
module tb_avr_dmem;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] d_addr;
   logic        data_write;
   logic [7:0]  d_wdata;
   logic [7:0]  d_rdata;
   logic        ext_req;
   logic [7:0]  ext_addr;
   logic [7:0]  ext_data;
   logic        ext_ack;
   logic        fifo_full;
   logic [2:0]  fifo_level;
   logic        err;
   logic        par_err;
   logic        err_clr;

   int errors = 0;
   int checks = 0;

   logic [7:0]  ram_m [int];
   logic [15:0] fm [$];
   int          exp_q [$];
   logic        err_m = 1'b0;
   logic        par_m = 1'b0;

   avr_dmem dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .d_addr     (d_addr),
      .data_write (data_write),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .ext_req    (ext_req),
      .ext_addr   (ext_addr),
      .ext_data   (ext_data),
      .ext_ack    (ext_ack),
      .fifo_full  (fifo_full),
      .fifo_level (fifo_level),
      .err        (err),
      .par_err    (par_err),
      .err_clr    (err_clr)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [15:0] a, input logic we,
                       input logic [7:0] wd, input logic ack,
                       input logic clr);
      int   e;
      logic pop, full, set, is_ram, is_ext;
      is_ram = (a >= 16'h0100) && (a < 16'h0300);
      is_ext = (a < 16'h0100);
      d_addr = a; data_write = we; d_wdata = wd;
      ext_ack = ack; err_clr = clr;
      if (is_ram) begin
         if (we)                          e = int'(wd);
         else if (ram_m.exists(int'(a)))  e = int'(ram_m[int'(a)]);
         else                             e = -1;
      end else begin
         e = 8'hFF;
      end
      exp_q.push_back(e);
      pop  = ack && (fm.size() != 0);
      full = (fm.size() == 4);
      set  = 1'b0;
      @(posedge CLK);
      #1;
      if (pop) void'(fm.pop_front());
      if (we) begin
         if (is_ram) ram_m[int'(a)] = wd;
         else if (is_ext) begin
            if (!full || pop) fm.push_back({a[7:0], wd});
            else              set = 1'b1;
         end else set = 1'b1;
      end
      if (set)      err_m = 1'b1;
      else if (clr) err_m = 1'b0;
      if (clr) par_m = 1'b0;
      e = exp_q.pop_front();
      if (e >= 0) chk("d_rdata", 16'(d_rdata), 16'(e));
      chk("ext_req", 16'(ext_req), 16'(fm.size() != 0));
      chk("fifo_level", 16'(fifo_level), 16'(fm.size()));
      chk("fifo_full", 16'(fifo_full), 16'(fm.size() == 4));
      chk("err", 16'(err), 16'(err_m));
      chk("par_err", 16'(par_err), 16'(par_m));
      if (fm.size() != 0) chk("ext_head", {ext_addr, ext_data}, fm[0]);
   endtask

   initial begin
      RST_N = 1'b0; d_addr = '0; data_write = 1'b0;
      d_wdata = '0; ext_ack = 1'b0; err_clr = 1'b0;
      #2;
      chk("rst_rdata", 16'(d_rdata), 16'h0);
      chk("rst_req", 16'(ext_req), 16'h0);
      chk("rst_level", 16'(fifo_level), 16'h0);
      chk("rst_full", 16'(fifo_full), 16'h0);
      chk("rst_head", {ext_addr, ext_data}, 16'h0);
      chk("rst_err", {15'h0, err}, 16'h0);
      chk("rst_par", {15'h0, par_err}, 16'h0);
      #10;
      RST_N = 1'b1;

      // RAM read/write, window edges, write-first
      step(16'h0100, 1, 8'hA5, 0, 0);
      step(16'h0100, 0, 8'h00, 0, 0);
      step(16'h02FF, 1, 8'h3C, 0, 0);
      step(16'h02FF, 0, 8'h00, 0, 0);
      step(16'h0150, 1, 8'h11, 0, 0);
      step(16'h0150, 1, 8'h77, 0, 0);
      step(16'h0150, 0, 8'h00, 0, 0);
      step(16'h0010, 0, 8'h00, 0, 0);
      step(16'h00FF, 0, 8'h00, 0, 0);
      step(16'h0300, 0, 8'h00, 0, 0);
      step(16'h0400, 0, 8'h00, 0, 0);

      // fill FIFO with ack low; fifth push overflows
      for (int i = 0; i < 5; i++)
         step(16'h0010 + 16'(i), 1, 8'h01 + 8'(i), 0, 0);
      chk("ovf_err", {15'h0, err}, 16'h1);
      chk("ovf_head", {ext_addr, ext_data}, 16'h1001);
      for (int i = 0; i < 5; i++)
         step(16'h0100, 0, 8'h00, 1, 0);
      chk("drained", {15'h0, ext_req}, 16'h0);
      step(16'h0100, 0, 8'h00, 0, 1);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++)
         step(16'h0030 + 16'(i), 1, 8'hC0 + 8'(i), 0, 0);
      step(16'h0020, 1, 8'hAB, 1, 0);
      chk("fullpp_lvl", 16'(fifo_level), 16'h4);
      chk("fullpp_err", {15'h0, err}, 16'h0);
      for (int i = 0; i < 4; i++)
         step(16'h02FF, 0, 8'h00, 1, 0);

      // unmapped access and err set/clear priority
      step(16'h0400, 1, 8'h99, 0, 0);
      step(16'h0100, 0, 8'h00, 0, 0);
      step(16'h0400, 0, 8'h00, 0, 0);
      step(16'h0500, 1, 8'h55, 0, 1);
      chk("clr_prio", {15'h0, err}, 16'h1);
      step(16'h0100, 0, 8'h00, 0, 1);

`ifdef AVR_DMEM_PARITY_EN
      dut.mem_q[0][8] = ~dut.mem_q[0][8];
      step(16'h0100, 0, 8'h00, 0, 0);
      par_m = 1'b1;
      step(16'h0010, 0, 8'h00, 0, 0);
      step(16'h0010, 0, 8'h00, 0, 1);
`endif

      // asynchronous reset with pending entries
      for (int i = 0; i < 3; i++)
         step(16'h0040 + 16'(i), 1, 8'h50 + 8'(i), 0, 0);
      step(16'h0400, 1, 8'h00, 0, 0);
      chk("pre_rst_req", {15'h0, ext_req}, 16'h1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("arst_req", {15'h0, ext_req}, 16'h0);
      chk("arst_level", 16'(fifo_level), 16'h0);
      chk("arst_head", {ext_addr, ext_data}, 16'h0);
      chk("arst_rdata", 16'(d_rdata), 16'h0);
      chk("arst_err", {15'h0, err}, 16'h0);
      fm.delete();
      ram_m.delete();
      err_m = 1'b0;
      par_m = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      step(16'h0010, 1, 8'h66, 0, 0);
      step(16'h0010, 0, 8'h00, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
